// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: load/store opcodes, bus size
// encodings, FSM state type and opcode classification helpers.
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_B;
      OP_LH, OP_LHU, OP_SH: return SIZE_H;
      default:              return SIZE_W;
    endcase
  endfunction

  // Only real memory ops can be misaligned; ALU ops carry arbitrary results.
  function automatic logic addr_misaligned(input logic [5:0] op, input logic [31:0] addr);
    logic [1:0] size;
    if (!(is_load_op(op) || is_store_op(op))) return 1'b0;
    size = op_size(op);
    case (size)
      SIZE_H:  return addr[0];
      SIZE_W:  return addr[1:0] != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data alignment: store-lane replication, load-lane extraction
// with sign/zero extension, and misalignment detection.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [1:0]  size,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size       = op_size(op);
    misaligned = addr_misaligned(op, addr);

    case (size)
      SIZE_B:  wdata = {4{rt[7:0]}};
      SIZE_H:  wdata = {2{rt[15:0]}};
      default: wdata = rt;
    endcase

    case (addr[1:0])
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: latches execute results, runs one SRAM-like bus
// transaction per load/store and presents the write-back result.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_in,
  input  logic        exe_valid,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_rt,
  input  logic [4:0]  exe_write_reg,
  input  logic        exe_reg_write,
  input  logic        exe_mem_read,
  input  logic        exe_mem_write,
  input  logic [31:0] exe_inst,
  input  logic [31:0] exe_pc,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_write_reg,
  output logic        wb_reg_write,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        ex_adel,
  output logic        ex_ades,
  output logic [31:0] bad_vaddr
);

  logic        vld_p0;
  logic [31:0] alu_p0;
  logic [31:0] rt_p0;
  logic [4:0]  write_reg_p0;
  logic        reg_write_p0;
  logic        mem_read_p0;
  logic        mem_write_p0;
  logic [31:0] inst_p0;
  logic [31:0] pc_p0;
  logic [31:0] load_buf_p0;
  state_t      state;

  logic        advance;
  logic [5:0]  exe_op;
  logic        exe_go;
  logic [5:0]  op_p0;
  logic        ld_p0;
  logic        st_p0;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        misaligned;

  assign mem_stall = (state == S_REQ) || (state == S_WAIT);
  assign advance   = !stall_in && !mem_stall;
  assign exe_op    = exe_inst[31:26];
  assign exe_go    = exe_valid &&
                     ((exe_mem_read && is_load_op(exe_op)) ||
                      (exe_mem_write && is_store_op(exe_op))) &&
                     !addr_misaligned(exe_op, exe_alu_result);

  // Stage p0: execute -> memory pipeline register, bus FSM and load buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0       <= 1'b0;
      alu_p0       <= '0;
      rt_p0        <= '0;
      write_reg_p0 <= '0;
      reg_write_p0 <= 1'b0;
      mem_read_p0  <= 1'b0;
      mem_write_p0 <= 1'b0;
      inst_p0      <= '0;
      pc_p0        <= RESET_PC;
      load_buf_p0  <= '0;
      state        <= S_IDLE;
    end else begin
      if (advance) begin
        vld_p0       <= exe_valid;
        alu_p0       <= exe_alu_result;
        rt_p0        <= exe_rt;
        write_reg_p0 <= exe_write_reg;
        reg_write_p0 <= exe_reg_write;
        mem_read_p0  <= exe_mem_read;
        mem_write_p0 <= exe_mem_write;
        inst_p0      <= exe_inst;
        pc_p0        <= exe_pc;
        state        <= exe_go ? S_REQ : S_IDLE;
      end else begin
        // Handshakes outside REQ/WAIT are spurious and fall through to default.
        case (state)
          S_REQ: begin
            if (data_addr_ok) begin
              if (data_data_ok) begin
                state       <= S_DONE;
                load_buf_p0 <= data_rdata;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (data_data_ok) begin
              state       <= S_DONE;
              load_buf_p0 <= data_rdata;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  assign op_p0 = inst_p0[31:26];
  assign ld_p0 = vld_p0 && mem_read_p0 && is_load_op(op_p0);
  assign st_p0 = vld_p0 && mem_write_p0 && is_store_op(op_p0);

  mem_align u_align (
    .op         (op_p0),
    .addr       (alu_p0),
    .rt         (rt_p0),
    .rdata      (load_buf_p0),
    .size       (size),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // Stage p0 outputs: bus request fields and write-back result
  always_comb begin
    data_req     = (state == S_REQ);
    data_wr      = st_p0;
    data_size    = size;
    data_addr    = alu_p0;
    data_wdata   = wdata;
    ex_adel      = ld_p0 && misaligned;
    ex_ades      = st_p0 && misaligned;
    bad_vaddr    = (ex_adel || ex_ades) ? alu_p0 : 32'd0;
    wb_valid     = vld_p0 && ((state == S_IDLE) || (state == S_DONE));
    wb_result    = ld_p0 ? load_data : alu_p0;
    wb_write_reg = write_reg_p0;
    wb_reg_write = wb_valid && reg_write_p0 && !misaligned;
    pc_out       = pc_p0;
    inst_out     = inst_p0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-plus-random bench for mem_stage: a behavioural bus slave and a
// reference model of alignment/extension rules predict every observed value.
module tb_mem_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_in;
  logic        exe_valid;
  logic [31:0] exe_alu_result;
  logic [31:0] exe_rt;
  logic [4:0]  exe_write_reg;
  logic        exe_reg_write;
  logic        exe_mem_read;
  logic        exe_mem_write;
  logic [31:0] exe_inst;
  logic [31:0] exe_pc;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_stall;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_write_reg;
  logic        wb_reg_write;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        ex_adel;
  logic        ex_ades;
  logic [31:0] bad_vaddr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn), .stall_in(stall_in), .exe_valid(exe_valid),
    .exe_alu_result(exe_alu_result), .exe_rt(exe_rt), .exe_write_reg(exe_write_reg),
    .exe_reg_write(exe_reg_write), .exe_mem_read(exe_mem_read),
    .exe_mem_write(exe_mem_write), .exe_inst(exe_inst), .exe_pc(exe_pc),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_write_reg(wb_write_reg),
    .wb_reg_write(wb_reg_write), .pc_out(pc_out), .inst_out(inst_out),
    .ex_adel(ex_adel), .ex_ades(ex_ades), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_is_ld(input logic [5:0] op);
    return op inside {6'h20, 6'h24, 6'h21, 6'h25, 6'h23};
  endfunction

  function automatic bit m_is_st(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic int m_bytes(input logic [5:0] op);
    if (op inside {6'h20, 6'h24, 6'h28}) return 1;
    if (op inside {6'h21, 6'h25, 6'h29}) return 2;
    return 4;
  endfunction

  // Load value from the spec's lane/extension rules using plain arithmetic.
  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    longint v;
    int     nb;
    nb = m_bytes(op);
    if (nb == 4) return rd;
    v = longint'((rd >> (8 * (addr % 4))) % (1 << (8 * nb)));
    if ((op == 6'h20 || op == 6'h21) && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] rt);
    int nb;
    nb = m_bytes(op);
    if (nb == 1) return (rt % 256) * 32'h0101_0101;
    if (nb == 2) return (rt % 65536) * 32'h0001_0001;
    return rt;
  endfunction

  // Issue one instruction, play the bus slave with the given latencies, and
  // check the request phase and the resulting write-back.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rd, input int a_lat, input int d_lat,
                        input logic [4:0] wreg);
    bit ld, st, mis;
    int k, exp_stall, nb;
    logic [31:0] pc, inst, exp_res;
    ld  = m_is_ld(op);
    st  = m_is_st(op);
    nb  = m_bytes(op);
    mis = (ld || st) && (addr % nb != 0);
    pc  = $urandom;
    inst = {op, 26'($urandom)};
    exe_valid = 1'b1; exe_alu_result = addr; exe_rt = rt; exe_write_reg = wreg;
    exe_reg_write = !st; exe_mem_read = ld; exe_mem_write = st;
    exe_inst = inst; exe_pc = pc;
    @(negedge clk);
    exe_valid = 1'b0; exe_mem_read = 1'b0; exe_mem_write = 1'b0;
    check("pc_out", pc_out, pc);
    check("inst_out", inst_out, inst);
    check("ex_adel", {31'd0, ex_adel}, {31'd0, ld && mis});
    check("ex_ades", {31'd0, ex_ades}, {31'd0, st && mis});
    if (mis) check("bad_vaddr", bad_vaddr, addr);
    k = 0;
    while (mem_stall === 1'b1 && k < 40) begin
      check("data_req", {31'd0, data_req}, {31'd0, k <= a_lat});
      if (k <= a_lat) begin
        check("data_addr", data_addr, addr);
        check("data_wr", {31'd0, data_wr}, {31'd0, st});
        check("data_size", {30'd0, data_size}, (nb == 1) ? 32'd0 : (nb == 2) ? 32'd1 : 32'd2);
        if (st) check("data_wdata", data_wdata, m_wdata(op, rt));
      end
      data_addr_ok = (k == a_lat);
      data_data_ok = (k == a_lat + d_lat);
      data_rdata   = data_data_ok ? rd : $urandom;
      @(negedge clk);
      k++;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    exp_stall = ((ld || st) && !mis) ? a_lat + 1 + d_lat : 0;
    exp_res   = (ld && !mis) ? m_load(op, addr, rd) : addr;
    check("stall_cycles", 32'(k), 32'(exp_stall));
    check("data_req_idle", {31'd0, data_req}, 32'd0);
    check("wb_valid", {31'd0, wb_valid}, 32'd1);
    check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, !st && !mis});
    check("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, wreg});
    if (!mis) check("wb_result", wb_result, exp_res);
  endtask

  logic [5:0] ops [9] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h00};

  initial begin
    rstn = 1'b0; stall_in = 1'b0; exe_valid = 1'b0; exe_alu_result = '0; exe_rt = '0;
    exe_write_reg = '0; exe_reg_write = 1'b0; exe_mem_read = 1'b0; exe_mem_write = 1'b0;
    exe_inst = '0; exe_pc = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_data_req", {31'd0, data_req}, 32'd0);
    check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_ex_adel", {31'd0, ex_adel}, 32'd0);
    check("rst_pc_out", pc_out, RESET_PC);
    rstn = 1'b1;
    @(negedge clk);

    run_op(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 5'd3);
    check("lw_value", wb_result, 32'hDEADBEEF);
    run_op(6'h20, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 3, 5'd4);
    check("lb_value", wb_result, 32'hFFFF_FF80);
    run_op(6'h24, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 3, 5'd4);
    check("lbu_value", wb_result, 32'h0000_0080);
    run_op(6'h29, 32'h202, 32'h1234_ABCD, 32'h0, 5, 0, 5'd0);
    run_op(6'h23, 32'h105, 32'h0, 32'h0, 0, 0, 5'd7);
    check("lw_mis_bad_vaddr", bad_vaddr, 32'h105);

    // Load completes while downstream holds the pipeline
    exe_valid = 1'b1; exe_alu_result = 32'h300; exe_write_reg = 5'd9; exe_reg_write = 1'b1;
    exe_mem_read = 1'b1; exe_mem_write = 1'b0; exe_inst = {6'h23, 26'd0}; exe_pc = 32'h1000;
    @(negedge clk);
    stall_in = 1'b1;
    exe_alu_result = 32'h55; exe_mem_read = 1'b0; exe_inst = 32'h0; exe_pc = 32'h2000;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1122_3344;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    check("stall_mem_stall", {31'd0, mem_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_wb_result", wb_result, 32'h1122_3344);
      check("stall_pc_hold", pc_out, 32'h1000);
      @(negedge clk);
    end
    stall_in = 1'b0;
    @(negedge clk);
    check("stall_release_pc", pc_out, 32'h2000);
    check("stall_release_res", wb_result, 32'h55);
    exe_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of an outstanding transaction
    exe_valid = 1'b1; exe_alu_result = 32'h104; exe_mem_read = 1'b1; exe_reg_write = 1'b1;
    exe_inst = {6'h20, 26'd0}; exe_pc = 32'h3000;
    @(negedge clk);
    exe_valid = 1'b0; exe_mem_read = 1'b0;
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    check("wait_data_req", {31'd0, data_req}, 32'd0);
    check("wait_mem_stall", {31'd0, mem_stall}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_data_req", {31'd0, data_req}, 32'd0);
    check("arst_mem_stall", {31'd0, mem_stall}, 32'd0);
    check("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("arst_pc_out", pc_out, RESET_PC);
    @(negedge clk);
    rstn = 1'b1;
    run_op(6'h00, 32'hCAFE_0001, 32'h0, 32'h0, 0, 0, 5'd12);

    for (int n = 0; n < 30; n++) begin
      logic [5:0]  op;
      logic [31:0] addr;
      int          nb;
      op   = ops[$urandom_range(0, 8)];
      nb   = m_bytes(op);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % nb);
      run_op(op, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             5'($urandom_range(1, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
